// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard scan-code controller.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Keyboard status/response bytes that never form part of a key event
  localparam int N_DISCARD = 6;
  localparam logic [N_DISCARD-1:0][7:0] DISCARD_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } pop_state_t;

  function automatic logic is_discard(input logic [7:0] b);
    is_discard = 1'b0;
    for (int i = 0; i < N_DISCARD; i++)
      if (b == DISCARD_CODES[i]) is_discard = 1'b1;
  endfunction

endpackage

// File: rtl/ps2_code_parser.sv
// Prefix / pause-sequence parser. Consumes one scan byte per i_en strobe and
// flags when that byte completes a key event; o_ext/o_brk are the prefix
// flags accumulated before the byte.
module ps2_code_parser
  import ps2_pkg::*;
#(
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic       o_evt,
  output logic       o_ext,
  output logic       o_brk
);

  localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  logic              r_ext;
  logic              r_brk;
  logic [SKIP_W-1:0] r_skip;
  logic              w_evt;

  // An event is any non-prefix, non-status byte outside a pause sequence
  always_comb begin
    w_evt = 1'b0;
    if (i_en && (r_skip == '0) && (i_byte != PFX_PAUSE) && (i_byte != PFX_EXT) &&
        (i_byte != PFX_BRK) && !is_discard(i_byte))
      w_evt = 1'b1;
  end

  // Prefix flags and pause-skip counter advance once per consumed byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
    end else if (i_en) begin
      if (r_skip != '0) begin
        r_skip <= r_skip - SKIP_W'(1);
      end else if (i_byte == PFX_PAUSE) begin
        r_skip <= SKIP_W'(PAUSE_SKIP);
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end else if (i_byte == PFX_EXT) begin
        r_ext <= 1'b1;
      end else if (i_byte == PFX_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign o_evt = w_evt;
  assign o_ext = r_ext;
  assign o_brk = r_brk;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops scan bytes from the receiver FIFO, decodes
// them into key events, tracks the currently held key and counts presses.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PAUSE_SKIP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  pop_state_t       r_state, w_state_nxt;
  logic             w_pop;
  logic             w_evt, w_ext, w_brk;
  logic [8:0]       w_key;
  logic             r_nextdata_n;
  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic             r_key_ext, r_key_break;
  logic [8:0]       r_held;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Pop FSM next state: take a byte only from IDLE, then spend one cycle in ACK
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: if (kb_ready) begin
        w_pop       = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; the pop strobe is low exactly while in ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_nextdata_n <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_nextdata_n <= (w_state_nxt != ST_ACK);
    end
  end

  // The byte is parsed on the same edge it is taken from the FIFO
  ps2_code_parser #(.PAUSE_SKIP(PAUSE_SKIP)) u_parser (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_pop),
    .i_byte (kb_data),
    .o_evt  (w_evt),
    .o_ext  (w_ext),
    .o_brk  (w_brk)
  );

  assign w_key = {w_ext, kb_data};

  // Event outputs, held-key tracking (typematic repeats are not recounted)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_held      <= '0;
      r_cnt       <= '0;
    end else begin
      r_key_valid <= w_evt;
      if (w_evt) begin
        r_key_code  <= kb_data;
        r_key_ext   <= w_ext;
        r_key_break <= w_brk;
        if (!w_brk) begin
          if (w_key != r_held) begin
            r_held <= w_key;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end else if (w_key == r_held) begin
          r_held <= '0;
        end
      end
    end
  end

  // Sticky overflow error; decoding is unaffected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | kb_overflow;
  end

  assign nextdata_n = r_nextdata_n;
  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_break  = r_key_break;
  assign held_code  = r_held;
  assign press_cnt  = r_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a model receiver FIFO feeds bytes, expected
// key events are queued as bytes are pushed and matched on each key_valid.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       nextdata_n, key_valid, key_ext, key_break, err;
  logic [7:0] key_code;
  logic [8:0] held_code;
  logic [7:0] press_cnt;

  ps2_kbd_ctrl #(.CNT_W(8), .PAUSE_SKIP(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .nextdata_n  (nextdata_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .held_code   (held_code),
    .press_cnt   (press_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_pop = 0;
  int         p0;
  logic       pend = 1'b0;
  logic       prev_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    kb_data  = fifo[0];
    kb_ready = 1'b1;
  endtask

  task automatic ev(input logic [7:0] c, input logic e, input logic b);
    exp_q.push_back({c, e, b});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ndn"},  nextdata_n, 1);
    chk({tag, "_kv"},   key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_ext"},  key_ext, 0);
    chk({tag, "_brk"},  key_break, 0);
    chk({tag, "_held"}, held_code, 0);
    chk({tag, "_cnt"},  press_cnt, 0);
    chk({tag, "_err"},  err, 0);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((fifo.size() != 0 || nextdata_n !== 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drain_timeout"}, t < 2000, 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_events_left"}, exp_q.size(), 0);
  endtask

  // Receiver model: the byte shown during an ACK cycle is removed on the edge ending it
  always @(posedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (fifo.size() > 0) fifo.delete(0);
      n_pop++;
      kb_ready = (fifo.size() != 0);
      if (kb_ready) kb_data = fifo[0];
    end
  end

  // A reset during ACK cancels the pop
  always @(posedge rst) pend = 1'b0;

  // Monitor: pop spacing and scoreboard match of every key event
  always @(negedge clk) begin
    if (rst) begin
      prev_low = 1'b0;
    end else begin
      if (nextdata_n === 1'b0) begin
        chk("pop_spacing", prev_low, 0);
        pend = 1'b1;
      end
      prev_low = (nextdata_n === 1'b0);
      if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ev_code", key_code, mon_e.code);
          chk("ev_ext", key_ext, mon_e.ext);
          chk("ev_brk", key_break, mon_e.brk);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single make: one-cycle pop, event in the same cycle
    push(8'h1C); ev(8'h1C, 0, 0);
    @(negedge clk);
    chk("make_ndn_low", nextdata_n, 0);
    chk("make_kv", key_valid, 1);
    @(negedge clk);
    chk("make_ndn_high", nextdata_n, 1);
    chk("make_kv_low", key_valid, 0);
    drain("make");
    chk("make_held", held_code, 9'h01C);
    chk("make_cnt", press_cnt, 1);

    // Release
    p0 = n_pop;
    push(8'hF0); push(8'h1C); ev(8'h1C, 0, 1);
    drain("brk");
    chk("brk_pops", n_pop - p0, 2);
    chk("brk_held", held_code, 0);
    chk("brk_cnt", press_cnt, 1);

    // Extended key with typematic repeat, then release
    push(8'hE0); push(8'h75); push(8'hE0); push(8'h75);
    ev(8'h75, 1, 0); ev(8'h75, 1, 0);
    drain("ext_make");
    chk("ext_held", held_code, 9'h175);
    chk("ext_cnt", press_cnt, 2);
    push(8'hE0); push(8'hF0); push(8'h75); ev(8'h75, 1, 1);
    drain("ext_brk");
    chk("ext_brk_held", held_code, 0);
    chk("ext_brk_cnt", press_cnt, 2);

    // Pause sequence is swallowed, following key decodes normally
    p0 = n_pop;
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1); push(8'hF0);
    push(8'h14); push(8'hF0); push(8'h77); push(8'h1C);
    ev(8'h1C, 0, 0);
    drain("pause");
    chk("pause_pops", n_pop - p0, 9);
    chk("pause_held", held_code, 9'h01C);
    chk("pause_cnt", press_cnt, 3);

    // Status byte clears a pending E0; repeat of held key is not counted
    push(8'hE0); push(8'hAA); push(8'h1C); ev(8'h1C, 0, 0);
    drain("discard");
    chk("discard_cnt", press_cnt, 3);
    chk("discard_ext", key_ext, 0);

    // Overflow is sticky, decoding continues
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_err", err, 1);
    push(8'h1D); ev(8'h1D, 0, 0);
    drain("ovf");
    chk("ovf_err_hold", err, 1);
    chk("ovf_cnt", press_cnt, 4);
    chk("ovf_held", held_code, 9'h01D);

    // Back-to-back bytes: pop strobe every second cycle
    for (int i = 0; i < 8; i++) begin
      push(8'h15 + 8'(i));
      ev(8'h15 + 8'(i), 0, 0);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("burst_ndn", nextdata_n, (k % 2 == 1) ? 0 : 1);
    end
    drain("burst");
    chk("burst_cnt", press_cnt, 12);
    chk("burst_held", held_code, 9'h01C);

    // Reset during ACK: strobe releases at once, byte stays queued
    push(8'h1C); ev(8'h1C, 0, 0); ev(8'h1C, 0, 0);
    @(negedge clk);
    chk("rack_ndn_low", nextdata_n, 0);
    #2 rst = 1'b1;
    #1 chk_zero("rack");
    @(negedge clk);
    @(negedge clk);
    chk("rack_fifo_kept", fifo.size(), 1);
    rst = 1'b0;
    drain("rack");
    chk("rack_cnt", press_cnt, 1);
    chk("rack_held", held_code, 9'h01C);

    // Counter at all-ones, then reset
    for (int i = 0; i < 254; i++) begin
      push((i % 2 == 1) ? 8'h16 : 8'h15);
      ev((i % 2 == 1) ? 8'h16 : 8'h15, 0, 0);
    end
    drain("fill1");
    chk("fill1_cnt", press_cnt, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("rst255");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Counter wrap on a fresh make after all-ones
    for (int i = 0; i < 255; i++) begin
      push((i % 2 == 1) ? 8'h16 : 8'h15);
      ev((i % 2 == 1) ? 8'h16 : 8'h15, 0, 0);
    end
    drain("fill2");
    chk("fill2_cnt", press_cnt, 8'hFF);
    chk("fill2_held", held_code, 9'h015);
    push(8'h1C); ev(8'h1C, 0, 0);
    drain("wrap");
    chk("wrap_cnt", press_cnt, 0);
    chk("wrap_held", held_code, 9'h01C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
